board_sprite_sched: RTL and testbench



---
 rtl/board_sprite_sched.sv | 153 +++++++++++++++
 tb/tb_board_sprite_sched.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/board_sprite_sched.sv
// board_sprite_sched: per-pixel scheduler sharing one sprite ROM bank across
// the 64 chess squares. Holds the board state, maps DrawX/DrawY to a square,
// piece code and sprite address, drives the shared ROM, and merges the
// returned palette index with the square background. Latency is 3 clocks.
// Optional build macro: SQ_CURSOR_EN adds a square-outline cursor overlay.
module board_sprite_sched #(
  parameter int BOARD_X0   = 80,
  parameter int SQ         = 60,
  parameter int TRANSP_IDX = 0
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic       blank,
  input  logic       upd_valid,
  output logic       upd_ready,
  input  logic [5:0] upd_square,
  input  logic [3:0] upd_piece,
  output logic       upd_err,
  output logic [3:0] rom_sel,
  output logic [11:0] rom_addr,
  input  logic [3:0] rom_q,
  output logic [2:0] pix_sel,
  output logic [3:0] pix_idx,
  output logic       pix_valid
`ifdef SQ_CURSOR_EN
  ,
  input  logic       cursor_on,
  input  logic [5:0] cursor_sq
`endif
);

  localparam int SW = $clog2(SQ);
  localparam logic [9:0] X0  = 10'(BOARD_X0);
  localparam logic [9:0] SQW = 10'(SQ);
  localparam logic [9:0] BW  = 10'(8 * SQ);
  localparam logic [3:0] TI  = 4'(TRANSP_IDX);

  function automatic logic legal_code(input logic [3:0] c);
    return !(c == 4'd7 || c == 4'd8 || c == 4'd15);
  endfunction

  function automatic logic [3:0] start_piece(input int i);
    logic [3:0] back;
    case (i % 8)
      0, 7:    back = 4'd4;
      1, 6:    back = 4'd2;
      2, 5:    back = 4'd3;
      3:       back = 4'd5;
      default: back = 4'd6;
    endcase
    case (i / 8)
      0:       return back + 4'd8;
      1:       return 4'd9;
      6:       return 4'd1;
      7:       return back;
      default: return 4'd0;
    endcase
  endfunction

  logic [3:0] board [64];

  // S0 registers and their combinational square decode
  logic [9:0] x0, y0;
  logic       blank0;
  logic [9:0] dx0;
  logic       on0;
  logic [2:0] col0, row0;
  logic [SW-1:0] sx0, sy0;
  logic       cur0;

  // S1 / S2 pipeline registers
  logic [3:0]  piece1, piece2;
  logic [11:0] addr1;
  logic        light1, light2, on1, on2, blank1, blank2, cur1, cur2;

  assign upd_ready = ~blank;

  assign dx0  = x0 - X0;
  assign on0  = (dx0 < BW) && (y0 < BW);
  assign col0 = 3'(dx0 / SQW);
  assign row0 = 3'(y0 / SQW);
  assign sx0  = SW'(dx0 % SQW);
  assign sy0  = SW'(y0 % SQW);

`ifdef SQ_CURSOR_EN
  // Outline is two pixels wide on each edge of the selected square
  assign cur0 = cursor_on && on0 && ({row0, col0} == cursor_sq) &&
                ((sx0 < SW'(2)) || (sx0 >= SW'(SQ - 2)) ||
                 (sy0 < SW'(2)) || (sy0 >= SW'(SQ - 2)));
`else
  assign cur0 = 1'b0;
`endif

  // Board storage: reset restores the opening position; illegal codes store as empty
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) board[i] <= start_piece(i);
      upd_err <= 1'b0;
    end else begin
      upd_err <= 1'b0;
      if (upd_valid && upd_ready) begin
        board[upd_square] <= legal_code(upd_piece) ? upd_piece : 4'd0;
        upd_err <= ~legal_code(upd_piece);
      end
    end
  end

  // Pixel pipeline: S0 capture, S1 board read, S2 ROM request, S3 merge
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      x0 <= '0; y0 <= '0; blank0 <= 1'b0;
      piece1 <= '0; addr1 <= '0; light1 <= 1'b0; on1 <= 1'b0; blank1 <= 1'b0; cur1 <= 1'b0;
      piece2 <= '0; light2 <= 1'b0; on2 <= 1'b0; blank2 <= 1'b0; cur2 <= 1'b0;
      rom_sel <= '0; rom_addr <= '0;
      pix_sel <= '0; pix_idx <= '0; pix_valid <= 1'b0;
    end else begin
      x0     <= DrawX;
      y0     <= DrawY;
      blank0 <= blank;

      piece1 <= on0 ? board[{row0, col0}] : 4'd0;
      addr1  <= 12'(sy0) * 12'(SQ) + 12'(sx0);
      light1 <= ~(row0[0] ^ col0[0]);
      on1    <= on0;
      blank1 <= blank0;
      cur1   <= cur0;

      rom_sel  <= on1 ? piece1 : 4'd0;
      rom_addr <= on1 ? addr1 : 12'd0;
      piece2   <= on1 ? piece1 : 4'd0;
      light2   <= light1;
      on2      <= on1;
      blank2   <= blank1;
      cur2     <= cur1;

      pix_valid <= blank2;
      pix_idx   <= 4'd0;
      if (!blank2 || !on2) begin
        pix_sel <= 3'd0;
      end else if (cur2) begin
        pix_sel <= 3'd4;
      end else if (piece2 != 4'd0 && rom_q != TI) begin
        pix_sel <= 3'd3;
        pix_idx <= rom_q;
      end else begin
        pix_sel <= light2 ? 3'd1 : 3'd2;
      end
    end
  end

endmodule

// File: tb/tb_board_sprite_sched.sv
// Directed bench for board_sprite_sched: pixel mapping, sprite/background
// merge, off-board boundaries, board update port and mid-frame reset.
module tb_board_sprite_sched;

  logic        vga_clk = 1'b0;
  logic        reset;
  logic [9:0]  DrawX, DrawY;
  logic        blank, upd_valid;
  logic        upd_ready, upd_err;
  logic [5:0]  upd_square;
  logic [3:0]  upd_piece, rom_sel, rom_q, pix_idx;
  logic [11:0] rom_addr;
  logic [2:0]  pix_sel;
  logic        pix_valid;
`ifdef SQ_CURSOR_EN
  logic        cursor_on = 1'b0;
  logic [5:0]  cursor_sq = 6'd0;
`endif

  int passed = 0;
  int total  = 0;

  board_sprite_sched dut (
    .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_square(upd_square),
    .upd_piece(upd_piece), .upd_err(upd_err), .rom_sel(rom_sel), .rom_addr(rom_addr),
    .rom_q(rom_q), .pix_sel(pix_sel), .pix_idx(pix_idx), .pix_valid(pix_valid)
`ifdef SQ_CURSOR_EN
    , .cursor_on(cursor_on), .cursor_sq(cursor_sq)
`endif
  );

  always #5 vga_clk = ~vga_clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Present one pixel, check the ROM request two edges after capture and
  // the merged output three edges after capture.
  task automatic px(input string tag, input logic [9:0] x, input logic [9:0] y,
                    input logic b, input logic [3:0] q,
                    input logic [3:0] e_sel, input logic [11:0] e_addr,
                    input logic [2:0] e_psel, input logic [3:0] e_idx, input logic e_val);
    @(negedge vga_clk);
    DrawX = x; DrawY = y; blank = b; rom_q = q;
    repeat (3) @(posedge vga_clk);
    #1;
    chk({tag, ".rom_sel"},  16'(rom_sel),  16'(e_sel));
    chk({tag, ".rom_addr"}, 16'(rom_addr), 16'(e_addr));
    @(posedge vga_clk);
    #1;
    chk({tag, ".pix_sel"},   16'(pix_sel),   16'(e_psel));
    chk({tag, ".pix_idx"},   16'(pix_idx),   16'(e_idx));
    chk({tag, ".pix_valid"}, 16'(pix_valid), 16'(e_val));
  endtask

  initial begin
    reset = 1'b1; DrawX = '0; DrawY = '0; blank = 1'b0; rom_q = '0;
    upd_valid = 1'b0; upd_square = '0; upd_piece = '0;
    #12;
    chk("rst.rom_sel",   16'(rom_sel),   16'd0);
    chk("rst.rom_addr",  16'(rom_addr),  16'd0);
    chk("rst.pix_sel",   16'(pix_sel),   16'd0);
    chk("rst.pix_idx",   16'(pix_idx),   16'd0);
    chk("rst.pix_valid", 16'(pix_valid), 16'd0);
    chk("rst.upd_err",   16'(upd_err),   16'd0);
    @(negedge vga_clk);
    reset = 1'b0;

    // Black rook top-left, opaque sprite pixel
    px("a8", 10'd80, 10'd0, 1'b1, 4'd5, 4'd12, 12'd0, 3'd3, 4'd5, 1'b1);
    // Row 2 col 2 empty light square, sy=10 sx=0 -> addr 600
    px("c6", 10'd200, 10'd130, 1'b1, 4'd7, 4'd0, 12'd600, 3'd1, 4'd0, 1'b1);
    // Boundaries
    px("x79",  10'd79,  10'd10,  1'b1, 4'd3, 4'd0, 12'd0, 3'd0, 4'd0, 1'b1);
    px("x560", 10'd560, 10'd10,  1'b1, 4'd3, 4'd0, 12'd0, 3'd0, 4'd0, 1'b1);
    px("y480", 10'd80,  10'd480, 1'b1, 4'd5, 4'd0, 12'd0, 3'd0, 4'd0, 1'b1);
    // Last on-board pixel: white rook h1, transparent -> light background
    px("h1", 10'd559, 10'd479, 1'b1, 4'd0, 4'd4, 12'd3599, 3'd1, 4'd0, 1'b1);
    // Black knight b8 transparent -> dark background
    px("b8", 10'd140, 10'd0, 1'b1, 4'd0, 4'd10, 12'd0, 3'd2, 4'd0, 1'b1);
    // Blanking suppresses the output
    px("blank", 10'd80, 10'd0, 1'b0, 4'd5, 4'd12, 12'd0, 3'd0, 4'd0, 1'b0);

    // Write white queen to square 36 during blanking
    @(negedge vga_clk);
    blank = 1'b0; upd_valid = 1'b1; upd_square = 6'd36; upd_piece = 4'd5;
    #1 chk("wr36.ready", 16'(upd_ready), 16'd1);
    @(posedge vga_clk);
    #1 chk("wr36.err", 16'(upd_err), 16'd0);
    @(negedge vga_clk);
    upd_valid = 1'b0;
    px("e4", 10'd320, 10'd270, 1'b1, 4'd9, 4'd5, 12'd1800, 3'd3, 4'd9, 1'b1);

    // Stalled write during active display leaves the board untouched
    @(negedge vga_clk);
    blank = 1'b1; upd_valid = 1'b1; upd_square = 6'd36; upd_piece = 4'd2;
    #1 chk("stall.ready", 16'(upd_ready), 16'd0);
    repeat (2) @(posedge vga_clk);
    #1 chk("stall.err", 16'(upd_err), 16'd0);
    @(negedge vga_clk);
    upd_valid = 1'b0;
    px("e4b", 10'd320, 10'd270, 1'b1, 4'd9, 4'd5, 12'd1800, 3'd3, 4'd9, 1'b1);

    // Illegal code 8 to square 0 stores empty and pulses upd_err once
    @(negedge vga_clk);
    blank = 1'b0; upd_valid = 1'b1; upd_square = 6'd0; upd_piece = 4'd8;
    @(posedge vga_clk);
    #1 chk("ill.err1", 16'(upd_err), 16'd1);
    @(negedge vga_clk);
    upd_valid = 1'b0;
    @(posedge vga_clk);
    #1 chk("ill.err2", 16'(upd_err), 16'd0);
    px("a8e", 10'd80, 10'd0, 1'b1, 4'd5, 4'd0, 12'd0, 3'd1, 4'd0, 1'b1);

    // Back-to-back writes to square 1: illegal 15 then black king 14
    @(negedge vga_clk);
    blank = 1'b0; upd_valid = 1'b1; upd_square = 6'd1; upd_piece = 4'd15;
    @(posedge vga_clk);
    #1 chk("b2b.err1", 16'(upd_err), 16'd1);
    @(negedge vga_clk);
    upd_piece = 4'd14;
    @(posedge vga_clk);
    #1 chk("b2b.err2", 16'(upd_err), 16'd0);
    @(negedge vga_clk);
    upd_valid = 1'b0;
    px("b8k", 10'd140, 10'd0, 1'b1, 4'd0, 4'd14, 12'd0, 3'd2, 4'd0, 1'b1);

    // Reset while a stream is in flight
    @(negedge vga_clk);
    DrawX = 10'd80; DrawY = 10'd0; blank = 1'b1; rom_q = 4'd5;
    repeat (2) @(posedge vga_clk);
    DrawX = 10'd81;
    repeat (3) @(posedge vga_clk);
    #1 chk("pre.pix_sel", 16'(pix_sel), 16'd1);
    #2 reset = 1'b1;
    #1;
    chk("mrst.rom_sel",   16'(rom_sel),   16'd0);
    chk("mrst.pix_sel",   16'(pix_sel),   16'd0);
    chk("mrst.pix_valid", 16'(pix_valid), 16'd0);
    chk("mrst.pix_idx",   16'(pix_idx),   16'd0);
    repeat (2) @(posedge vga_clk);
    @(negedge vga_clk);
    reset = 1'b0;
    px("e4r", 10'd320, 10'd270, 1'b1, 4'd9, 4'd0, 12'd1800, 3'd1, 4'd0, 1'b1);
    px("a8r", 10'd80, 10'd0, 1'b1, 4'd5, 4'd12, 12'd0, 3'd3, 4'd5, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
